// File: rtl/alu_result_stage_if.sv
// Result-stream bundle between the ALU output stage and its neighbours.
// The stage side uses the slave modport; the upstream/downstream
// environment (or a testbench) uses the master modport.
interface alu_result_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int RD_WIDTH   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_result;
  logic [RD_WIDTH-1:0]   in_rd;
  logic                  in_wr_en;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [RD_WIDTH-1:0]   out_rd;
  logic                  out_wr_en;
  logic                  out_zero;
  logic                  out_negative;

  modport slave (
    input  in_valid, in_result, in_rd, in_wr_en, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en, out_zero, out_negative
  );

  modport master (
    output in_valid, in_result, in_rd, in_wr_en, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en, out_zero, out_negative
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU operation units.
// Holds up to two results (MAIN drives the outputs, SKID catches the one
// extra beat that arrives while downstream stalls), so the stage streams
// at full rate while in_ready depends only on the state register.
// Zero/negative flags are derived once at capture and stored with the entry.
module alu_result_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int RD_WIDTH   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  alu_result_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [RD_WIDTH-1:0]   rd;
    logic                  wr_en;
    logic                  zero;
    logic                  negative;
  } entry_t;

  state_t state;
  state_t next_state;

  entry_t main_entry;
  entry_t skid_entry;
  entry_t in_entry;

  logic in_ready_int;
  logic out_valid_int;
  logic accept;
  logic pop;
  logic load_main;
  logic load_skid;
  logic shift_skid;

  // Handshake qualifiers decoded purely from the registered state so that
  // in_ready never has a combinational path from out_ready.
  always_comb begin
    in_ready_int  = (state != TWO);
    out_valid_int = (state != EMPTY);
    accept        = bus.in_valid & in_ready_int;
    pop           = out_valid_int & bus.out_ready;
  end

  // Package the incoming beat together with its flags, computed from the
  // raw input so the stored flags always match the stored result.
  always_comb begin
    in_entry          = '0;
    in_entry.result   = bus.in_result;
    in_entry.rd       = bus.in_rd;
    in_entry.wr_en    = bus.in_wr_en;
    in_entry.zero     = (bus.in_result == '0);
    in_entry.negative = bus.in_result[DATA_WIDTH-1];
  end

  // State register; reset empties the buffer regardless of what was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath steering. Flush wins over everything, discarding
  // both a presented input and a pending pop in the same cycle.
  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            next_state = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main  = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            next_state = TWO;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            shift_skid = 1'b1;
            next_state = ONE;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  // Entry storage. MAIN only changes on a load or a skid shift, which keeps
  // the outputs stable while downstream stalls. Stale data after a flush is
  // harmless because out_valid qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_entry <= '0;
      skid_entry <= '0;
    end else begin
      if (load_main) begin
        main_entry <= in_entry;
      end else if (shift_skid) begin
        main_entry <= skid_entry;
      end
      if (load_skid) begin
        skid_entry <= in_entry;
      end
    end
  end

  // Output drive; the side-band flags and write enable are gated by
  // out_valid so an empty stage never advertises a write or a flag.
  always_comb begin
    bus.in_ready     = in_ready_int;
    bus.out_valid    = out_valid_int;
    bus.out_result   = main_entry.result;
    bus.out_rd       = main_entry.rd;
    bus.out_wr_en    = out_valid_int & main_entry.wr_en;
    bus.out_zero     = out_valid_int & main_entry.zero;
    bus.out_negative = out_valid_int & main_entry.negative;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vectors with literal expectations plus
// a queue-based reference of the two-entry FIFO checked on every negedge.
module tb_alu_result_stage;

  localparam int DW = 64;
  localparam int RW = 5;

  typedef struct {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          wr_en;
  } item_t;

  logic clk;
  logic reset;
  logic flush;

  int checks;
  int errors;

  item_t model_q[$];

  alu_result_stage_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) bus ();

  alu_result_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic valid, input logic [DW-1:0] value, input logic [RW-1:0] rd, input logic wr_en);
    bus.in_valid  = valid;
    bus.in_result = value;
    bus.in_rd     = rd;
    bus.in_wr_en  = wr_en;
  endtask

  // Reference FIFO: capacity two, accept when not full, pop when non-empty
  // and downstream ready; flush discards everything including this cycle's beats.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit do_pop    = (model_q.size() > 0) && bus.out_ready;
      automatic bit do_accept = bus.in_valid && (model_q.size() < 2);
      automatic item_t it;
      it.result = bus.in_result;
      it.rd     = bus.in_rd;
      it.wr_en  = bus.in_wr_en;
      if (do_pop) void'(model_q.pop_front());
      if (do_accept) model_q.push_back(it);
    end
  end

  // Cycle-by-cycle comparison of every output against the reference FIFO head.
  always @(negedge clk) begin
    if (!reset) begin
      check("model in_ready", 64'(bus.in_ready), 64'(model_q.size() < 2));
      check("model out_valid", 64'(bus.out_valid), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check("model out_result", bus.out_result, model_q[0].result);
        check("model out_rd", 64'(bus.out_rd), 64'(model_q[0].rd));
        check("model out_wr_en", 64'(bus.out_wr_en), 64'(model_q[0].wr_en));
        check("model out_zero", 64'(bus.out_zero), 64'(model_q[0].result == 0));
        check("model out_negative", 64'(bus.out_negative), 64'(model_q[0].result[DW-1]));
      end else begin
        check("model idle wr_en", 64'(bus.out_wr_en), 64'd0);
        check("model idle zero", 64'(bus.out_zero), 64'd0);
        check("model idle negative", 64'(bus.out_negative), 64'd0);
      end
    end
  end

  task automatic apply_stimulus();
    logic [DW-1:0] v;
    // Reset state
    step();
    step();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_result", bus.out_result, 64'd0);
    check("reset out_rd", 64'(bus.out_rd), 64'd0);
    check("reset out_wr_en", 64'(bus.out_wr_en), 64'd0);
    check("reset out_zero", 64'(bus.out_zero), 64'd0);
    check("reset out_negative", 64'(bus.out_negative), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    step();

    // 1. Single beat, one-cycle latency
    bus.out_ready = 1'b1;
    drive_in(1'b1, 64'd435, 5'd3, 1'b1);
    step();
    check("t1 out_valid", 64'(bus.out_valid), 64'd1);
    check("t1 out_result", bus.out_result, 64'd435);
    check("t1 out_rd", 64'(bus.out_rd), 64'd3);
    check("t1 out_wr_en", 64'(bus.out_wr_en), 64'd1);
    check("t1 out_zero", 64'(bus.out_zero), 64'd0);
    check("t1 out_negative", 64'(bus.out_negative), 64'd0);

    // 2. Negative and zero flags
    drive_in(1'b1, 64'hFFFF_FFFF_FFFF_F307, 5'd7, 1'b1);
    step();
    check("t2 neg result", bus.out_result, 64'hFFFF_FFFF_FFFF_F307);
    check("t2 neg negative", 64'(bus.out_negative), 64'd1);
    check("t2 neg zero", 64'(bus.out_zero), 64'd0);
    drive_in(1'b1, 64'd0, 5'd0, 1'b0);
    step();
    check("t2 zero valid", 64'(bus.out_valid), 64'd1);
    check("t2 zero zero", 64'(bus.out_zero), 64'd1);
    check("t2 zero negative", 64'(bus.out_negative), 64'd0);
    check("t2 zero wr_en", 64'(bus.out_wr_en), 64'd0);
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    step();
    check("t2 drained", 64'(bus.out_valid), 64'd0);

    // 3. Stall fills both entries, third beat ignored
    bus.out_ready = 1'b0;
    drive_in(1'b1, 64'd435, 5'd1, 1'b1);
    step();
    check("t3 ready after 1st", 64'(bus.in_ready), 64'd1);
    check("t3 out after 1st", bus.out_result, 64'd435);
    drive_in(1'b1, 64'd7263, 5'd2, 1'b1);
    step();
    check("t3 ready after 2nd", 64'(bus.in_ready), 64'd0);
    check("t3 hold 435", bus.out_result, 64'd435);
    drive_in(1'b1, 64'd999, 5'd4, 1'b1);
    step();
    check("t3 ready still 0", 64'(bus.in_ready), 64'd0);
    check("t3 still 435", bus.out_result, 64'd435);
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    bus.out_ready = 1'b1;
    check("t3 first out", bus.out_result, 64'd435);
    step();
    check("t3 second valid", 64'(bus.out_valid), 64'd1);
    check("t3 second out", bus.out_result, 64'd7263);
    check("t3 second rd", 64'(bus.out_rd), 64'd2);
    step();
    check("t3 empty", 64'(bus.out_valid), 64'd0);

    // 4. Back-to-back streaming
    for (int i = 0; i < 100; i++) begin
      v = 64'h1000 + 64'(i) * 64'h0123_4567_89AB;
      drive_in(1'b1, v, 5'(i), 1'b1);
      step();
      check("t4 stream out", bus.out_result, v);
      check("t4 stream ready", 64'(bus.in_ready), 64'd1);
    end
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    step();

    // 5. Flush with two entries buffered, then with one
    bus.out_ready = 1'b0;
    drive_in(1'b1, 64'd41, 5'd1, 1'b1);
    step();
    drive_in(1'b1, 64'd42, 5'd2, 1'b1);
    step();
    flush = 1'b1;
    drive_in(1'b1, 64'd5, 5'd5, 1'b1);
    step();
    flush = 1'b0;
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    check("t5 flush valid", 64'(bus.out_valid), 64'd0);
    check("t5 flush ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5 no ghost", 64'(bus.out_valid), 64'd0);
    end
    bus.out_ready = 1'b0;
    drive_in(1'b1, 64'd43, 5'd3, 1'b1);
    step();
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 64'd5, 5'd5, 1'b1);
    step();
    flush = 1'b0;
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    check("t5 flush one valid", 64'(bus.out_valid), 64'd0);
    step();
    check("t5 flush one later", 64'(bus.out_valid), 64'd0);

    // 6. Asynchronous reset mid-cycle with two entries
    bus.out_ready = 1'b0;
    drive_in(1'b1, 64'hDEAD_BEEF, 5'd9, 1'b1);
    step();
    drive_in(1'b1, 64'h8000_0000_0000_0000, 5'd10, 1'b1);
    step();
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    check("t6 pre full", 64'(bus.in_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t6 async out_valid", 64'(bus.out_valid), 64'd0);
    check("t6 async out_result", bus.out_result, 64'd0);
    check("t6 async out_rd", 64'(bus.out_rd), 64'd0);
    check("t6 async out_wr_en", 64'(bus.out_wr_en), 64'd0);
    check("t6 async in_ready", 64'(bus.in_ready), 64'd1);
    step();
    reset = 1'b0;
    step();

    // Random traffic against the reference FIFO
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 7))
        0: v = 64'd0;
        1: v = {1'b1, 31'($urandom), 32'($urandom)};
        default: v = {32'($urandom), 32'($urandom)};
      endcase
      drive_in(1'($urandom_range(0, 1)), v, 5'($urandom), 1'($urandom_range(0, 1)));
      bus.out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 64'd0, 5'd0, 1'b0);
    $display("[TB] starting alu_result_stage bench");
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
